// File: rtl/mac_acc_2b.sv
// mac_acc_2b: accumulates N_SAMPLES unsigned 2b x 2b products into an ACC_W-bit result.
// Latency: the transfer that completes a result raises out_valid on the next cycle.
// Backpressure: DONE holds the result and drops in_ready until out_ready accepts it.
//
// Ports:
//   clk, rst_n           - clock and asynchronous active-low reset
//   in_valid / in_ready  - operand handshake for a, b (2-bit unsigned each)
//   clear                - synchronous abort to IDLE; beats any transfer in the same cycle
//   out_valid / out_ready- result handshake for acc_out and overflow
//   acc_out              - accumulator register (ACC_W bits)
//   overflow             - sticky flag: some addition of this result exceeded 2^ACC_W-1
//
// Optional feature: define MAC_ACC_SAT_EN to saturate the accumulator at 2^ACC_W-1
// on overflow; by default an overflowing addition wraps modulo 2^ACC_W.

module mac_acc_2b #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] N_LAST = 8'(N_SAMPLES);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       count;
    logic             ovf;
    // Low while in reset and until the first edge afterwards, so in_ready
    // reads 0 during reset even though the state is already IDLE.
    logic             armed;

    logic             in_xfer;
    logic [3:0]       prod;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] acc_next;
    logic [7:0]       count_next;
    logic             last;

    // in_ready depends only on registered state, never on in_valid/out_ready.
    assign in_ready  = armed & (state != DONE);
    assign out_valid = (state == DONE);
    assign acc_out   = acc;
    assign overflow  = ovf;

    assign in_xfer    = in_valid & in_ready;
    assign prod       = {2'b00, a} * {2'b00, b};
    // One extra bit on the sum exposes the carry out of the ACC_W-bit accumulator.
    assign sum        = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, prod};
    assign sum_ovf    = sum[ACC_W];
    assign count_next = count + 8'd1;
    assign last       = (count_next == N_LAST);

`ifdef MAC_ACC_SAT_EN
    // Once clamped at all-ones, any further non-zero product overflows again
    // and re-clamps, so the value stays pinned for the rest of the result.
    assign acc_next = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (clear) begin
                state <= IDLE;
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else begin
                case (state)
                    IDLE, ACCUM: begin
                        if (in_xfer) begin
                            acc   <= acc_next;
                            ovf   <= ovf | sum_ovf;
                            count <= count_next;
                            state <= last ? DONE : ACCUM;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state <= IDLE;
                            acc   <= '0;
                            count <= '0;
                            ovf   <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_2b.sv
// tb_mac_acc_2b: drives three mac_acc_2b instances (defaults, N_SAMPLES=16, ACC_W=5)
// from shared stimulus; each scenario task checks the selected instance.
// Expected results come from a behavioural model feeding a scoreboard queue.

module tb_mac_acc_2b;

`ifdef MAC_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] a = 2'd0;
    logic [1:0] b = 2'd0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;

    logic       ir0, ov0, of0;
    logic [7:0] acc0;
    logic       ir1, ov1, of1;
    logic [7:0] acc1;
    logic       ir2, ov2, of2;
    logic [4:0] acc2;

    always #5 clk = ~clk;

    mac_acc_2b #(.N_SAMPLES(4), .ACC_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .clear(clear), .out_valid(ov0), .out_ready(out_ready),
        .acc_out(acc0), .overflow(of0));

    mac_acc_2b #(.N_SAMPLES(16), .ACC_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .clear(clear), .out_valid(ov1), .out_ready(out_ready),
        .acc_out(acc1), .overflow(of1));

    mac_acc_2b #(.N_SAMPLES(4), .ACC_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .clear(clear), .out_valid(ov2), .out_ready(out_ready),
        .acc_out(acc2), .overflow(of2));

    // Selected instance view
    int          sel = 0;
    logic        ir_s, ov_s, of_s;
    logic [15:0] acc_s;

    always_comb begin
        ir_s = ir0; ov_s = ov0; of_s = of0; acc_s = {8'd0, acc0};
        case (sel)
            1: begin ir_s = ir1; ov_s = ov1; of_s = of1; acc_s = {8'd0, acc1}; end
            2: begin ir_s = ir2; ov_s = ov2; of_s = of2; acc_s = {11'd0, acc2}; end
            default: ;
        endcase
    end

    // Output handshakes seen on the selected instance
    int hs_cnt = 0;
    always @(posedge clk) if (rst_n && ov_s && out_ready) hs_cnt <= hs_cnt + 1;

    int errors = 0;
    int checks = 0;

    // Behavioural model + scoreboard: {overflow, acc}
    logic [16:0] sb_q[$];
    int m_acc = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;

    function automatic int model_n();
        return (sel == 1) ? 16 : 4;
    endfunction

    function automatic int model_max();
        return (sel == 2) ? 31 : 255;
    endfunction

    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
    endtask

    task automatic model_add(input int ma, input int mb);
        int tot;
        tot = m_acc + ma * mb;
        if (tot > model_max()) begin
            m_ovf = 1'b1;
            m_acc = SAT ? model_max() : tot % (model_max() + 1);
        end else begin
            m_acc = tot;
        end
        m_cnt++;
        if (m_cnt == model_n()) begin
            sb_q.push_back({m_ovf, 16'(m_acc)});
            model_clear();
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
        sb_q.delete();
    endtask

    // Presents one operand pair; returns at the negedge after it transferred.
    task automatic send(input logic [1:0] sa, input logic [1:0] sb);
        int w;
        in_valid = 1'b1; a = sa; b = sb; w = 0;
        while (!ir_s && w < 50) begin @(negedge clk); w++; end
        if (!ir_s) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", ir_s);
            in_valid = 1'b0;
        end else begin
            model_add(int'(sa), int'(sb));
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Waits for a result, compares with the scoreboard, checks the return to IDLE.
    task automatic collect(input int max_wait, output int waited);
        logic [16:0] exp;
        waited = 0;
        out_ready = 1'b1;
        while (!ov_s && waited < max_wait) begin @(negedge clk); waited++; end
        checks++;
        if (!ov_s) begin
            errors++;
            $display("FAIL collect_timeout: out_valid=%0b, required 1", ov_s);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: acc_out=%0d with empty scoreboard", acc_s);
        end else begin
            exp = sb_q.pop_front();
            if (acc_s !== exp[15:0]) begin
                errors++;
                $display("FAIL result_acc: acc_out=%0d, required %0d", acc_s, exp[15:0]);
            end
            checks++;
            if (of_s !== exp[16]) begin
                errors++;
                $display("FAIL result_ovf: overflow=%0b, required %0b", of_s, exp[16]);
            end
            @(negedge clk);
            checks++;
            if (ov_s !== 1'b0 || ir_s !== 1'b1 || acc_s !== 16'd0 || of_s !== 1'b0) begin
                errors++;
                $display("FAIL after_output: out_valid=%0b in_ready=%0b acc=%0d ovf=%0b, required 0 1 0 0",
                         ov_s, ir_s, acc_s, of_s);
            end
        end
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; a = 2'd3; b = 2'd3; out_ready = 1'b1;
        #1;
        checks++;
        if (ir_s !== 1'b0 || ov_s !== 1'b0 || acc_s !== 16'd0 || of_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b acc=%0d ovf=%0b, required all 0",
                     ir_s, ov_s, acc_s, of_s);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ir_s !== 1'b0 || acc_s !== 16'd0) begin
            errors++;
            $display("FAIL reset_held: in_ready=%0b acc=%0d, required 0 0", ir_s, acc_s);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_s !== 1'b1 || ov_s !== 1'b0 || acc_s !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b acc=%0d, required 1 0 0",
                     ir_s, ov_s, acc_s);
        end
        model_clear();
        sb_q.delete();
    endtask

    task automatic test_back_to_back();
        int w;
        sel = 0;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(2'd3, 2'd3);
        checks++;
        if (ov_s !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early_valid: out_valid=%0b after 3 transfers, required 0", ov_s);
        end
        send(2'd3, 2'd3);
        checks++;
        if (ov_s !== 1'b1 || acc_s !== 16'd36 || of_s !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: out_valid=%0b acc=%0d ovf=%0b, required 1 36 0", ov_s, acc_s, of_s);
        end
        collect(20, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL b2b_latency: waited %0d cycles, required 0", w);
        end
    endtask

    task automatic test_gaps();
        int w;
        sel = 1;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                send(2'(i), 2'(j));
                if (j % 2 == 1 && (i * 4 + j) < 15) begin
                    for (int g = 0; g < 2; g++) begin
                        @(negedge clk);
                        checks++;
                        if (acc_s !== 16'(m_acc) || ov_s !== 1'b0 || ir_s !== 1'b1) begin
                            errors++;
                            $display("FAIL gap_hold: acc=%0d out_valid=%0b in_ready=%0b, required %0d 0 1",
                                     acc_s, ov_s, ir_s, m_acc);
                        end
                    end
                end
            end
        end
        checks++;
        if (acc_s !== 16'd36) begin
            errors++;
            $display("FAIL gaps_sum: acc=%0d, required 36", acc_s);
        end
        collect(20, w);
    endtask

    task automatic test_backpressure();
        int w;
        sel = 0;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd3, 2'd3);
        in_valid = 1'b1; a = 2'd1; b = 2'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ov_s !== 1'b1 || acc_s !== 16'd36 || of_s !== 1'b0 || ir_s !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: out_valid=%0b acc=%0d ovf=%0b in_ready=%0b, required 1 36 0 0",
                         ov_s, acc_s, of_s, ir_s);
            end
        end
        in_valid = 1'b0;
        collect(1, w);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL bp_release: waited %0d cycles, required 0", w);
        end
    endtask

    task automatic test_overflow();
        int w;
        sel = 2;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd3, 2'd3);
        checks++;
        if (acc_s !== (SAT ? 16'd31 : 16'd4) || of_s !== 1'b1) begin
            errors++;
            $display("FAIL overflow_value: acc=%0d ovf=%0b, required %0d 1", acc_s, of_s, SAT ? 31 : 4);
        end
        collect(5, w);
    endtask

    task automatic test_clear();
        int w, hs0;
        sel = 0;
        apply_reset();
        out_ready = 1'b1;
        hs0 = hs_cnt;
        send(2'd3, 2'd3);
        send(2'd3, 2'd3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        checks++;
        if (acc_s !== 16'd0 || of_s !== 1'b0 || ov_s !== 1'b0 || ir_s !== 1'b1) begin
            errors++;
            $display("FAIL clear_state: acc=%0d ovf=%0b out_valid=%0b in_ready=%0b, required 0 0 0 1",
                     acc_s, of_s, ov_s, ir_s);
        end
        for (int i = 0; i < 4; i++) send(2'd1, 2'd2);
        collect(5, w);
        checks++;
        if (hs_cnt - hs0 != 1) begin
            errors++;
            $display("FAIL clear_results: %0d results emitted, required 1", hs_cnt - hs0);
        end
    endtask

    task automatic test_reset_done();
        int w, hs0;
        sel = 0;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd3, 2'd3);
        hs0 = hs_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov_s !== 1'b0 || acc_s !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_done: out_valid=%0b acc=%0d, required 0 0", ov_s, acc_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        sb_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ov_s !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_pulse: out_valid=%0b, required 0", ov_s);
            end
        end
        for (int i = 0; i < 4; i++) send(2'd2, 2'd1);
        checks++;
        if (acc_s !== 16'd8) begin
            errors++;
            $display("FAIL fresh_sum: acc=%0d, required 8", acc_s);
        end
        collect(5, w);
        checks++;
        if (hs_cnt - hs0 != 1) begin
            errors++;
            $display("FAIL reset_results: %0d results emitted, required 1", hs_cnt - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_overflow();
        test_clear();
        test_reset_done();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_acc_2b.md
MAC_ACC_2B -- requirements
Module: mac_acc_2b

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 4: the number of accepted operand pairs per result, legal range 1..255.
REQ-002 The block SHALL have parameter ACC_W, default 8: the accumulator width, legal range 4..16.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1: operand pair on a/b is valid.
REQ-006 The block SHALL have port in_ready, output, 1: the block can accept an operand pair.
REQ-007 The block SHALL have port a, input, 2: unsigned multiplicand.
REQ-008 The block SHALL have port b, input, 2: unsigned multiplier.
REQ-009 The block SHALL have port clear, input, 1: synchronous abort to IDLE.
REQ-010 The block SHALL have port out_valid, output, 1: acc_out holds a completed result.
REQ-011 The block SHALL have port out_ready, input, 1: the downstream stage accepts the result.
REQ-012 The block SHALL have port acc_out, output, ACC_W: the accumulated sum of products.
REQ-013 The block SHALL have port overflow, output, 1: the current result exceeded 2^ACC_W-1.

Function
REQ-014 Input transfer SHALL occur on a clock edge where in_valid=1 and in_ready=1; output transfer SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-015 Each transfer SHALL form product a*b as 4-bit unsigned (0..9), zero-extend it to ACC_W, and add it to the accumulator in that same edge.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE, the accumulator and sample count SHALL be 0, and in_ready=1.
REQ-018 The first transfer SHALL move IDLE to ACCUM, unless N_SAMPLES=1, in which case it SHALL move IDLE directly to DONE.
REQ-019 In ACCUM, in_ready SHALL be 1; the transfer that brings the count to N_SAMPLES SHALL move ACCUM to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and in_ready SHALL be 0; the transfer that completes the result SHALL cause out_valid to rise on the next cycle (latency 1 cycle).
REQ-021 While in DONE with out_ready=0, acc_out and overflow SHALL be held stable.
REQ-022 An output transfer SHALL move DONE to IDLE and clear the accumulator, count and overflow.
REQ-023 While in IDLE or ACCUM, in_valid=0 SHALL leave all state unchanged (bubbles allowed).
REQ-024 clear=1 SHALL take priority over any input or output transfer in the same cycle: next state IDLE, accumulator, count and overflow zeroed, and out_valid=0 the next cycle.
REQ-025 overflow SHALL be sticky within a result: it SHALL be set on any addition whose true sum exceeds 2^ACC_W-1.
REQ-026 acc_out SHALL be driven from the accumulator register (registered output, no combinational path from a/b).
REQ-027 in_ready SHALL be a function of state only, with no combinational path from in_valid or out_ready.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, accumulator=0, count=0, out_valid=0, overflow=0, acc_out=0 and in_ready=0.
REQ-029 in_ready SHALL be 1 from the first clock edge after rst_n is released.
REQ-030 Reset asserted mid-accumulation or in DONE SHALL discard the partial or pending result, and no out_valid pulse SHALL follow.

Configuration
REQ-031 With macro MAC_ACC_SAT_EN defined, an overflowing addition SHALL clamp the accumulator to 2^ACC_W-1 and hold it there for the rest of the result, with overflow=1.
REQ-032 Without MAC_ACC_SAT_EN, an overflowing addition SHALL wrap modulo 2^ACC_W, with overflow=1; all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover: defaults, 4 transfers of (a=3,b=3) back-to-back with out_ready=1 -> acc_out=36, overflow=0, out_valid high exactly 1 cycle after the 4th transfer, then IDLE.
REQ-034 The bench SHALL cover: N_SAMPLES=16, all 16 (a,b) pairs 0..3 x 0..3 in nested order -> acc_out=36, with in_valid gaps inserted causing no change.
REQ-035 The bench SHALL cover: backpressure, result 36 with out_ready=0 for 5 cycles -> acc_out=36 stable, in_ready=0 with in_valid=1 ignored, and transfer on the cycle out_ready=1.
REQ-036 The bench SHALL cover: ACC_W=5, 4 x (3,3) -> without MAC_ACC_SAT_EN acc_out=4 with overflow=1; with the macro acc_out=31 with overflow=1.
REQ-037 The bench SHALL cover: clear after 2 x (3,3), then 4 x (1,2) -> acc_out=8 with overflow=0, and no result emitted for the aborted pair.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-cycle while in DONE -> out_valid=0 before the next edge; after release, a fresh 4 x (2,1) -> acc_out=8.
